muldiv_sequencer: RTL and testbench

- Multi-cycle multiply/divide unit that owns the HI/LO registers of the MIPS core.
- Sits beside the single-cycle ALU in the EX stage.
- Accepts MULT/MULTU/DIV/DIVU issued from EX and sequences a radix-2 iterative shift-add / restoring-divide datapath over WIDTH cycles.
- Drives stall_FETCH so that any HI/LO consumer, or a new mul/div, waits until the result is committed.

---
 rtl/muldiv_sequencer.sv | 157 +++++++++++++++
 tb/tb_muldiv_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit owning HI/LO: radix-2 shift-add multiply and
// restoring divide over WIDTH cycles, with sign fixup and commit in a final FIX cycle.
module muldiv_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_EX,
  input  logic [1:0]       op_EX,
  input  logic [WIDTH-1:0] a_EX,
  input  logic [WIDTH-1:0] b_EX,
  input  logic             hilo_read_EX,
  input  logic             mthi_EX,
  input  logic             mtlo_EX,
  input  logic [WIDTH-1:0] wdata_EX,
  output logic             busy,
  output logic             stall_FETCH,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             done
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam int unsigned ACC_W = 2 * WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   opd_q, opd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               negq_q, negq_d;
  logic               negr_q, negr_d;
  logic               bzero_q, bzero_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               signed_op, sa, sb, b_is_zero;
  logic [WIDTH-1:0]   abs_a, abs_b, quo, rem;
  logic [WIDTH:0]     mul_sum, div_trial;
  logic [ACC_W:0]     div_sh;
  logic [ACC_W-1:0]   iter_val;

  // Operand preparation for the capture edge
  assign signed_op = ~op_EX[0];
  assign sa        = signed_op & a_EX[WIDTH-1];
  assign sb        = signed_op & b_EX[WIDTH-1];
  assign abs_a     = sa ? -a_EX : a_EX;
  assign abs_b     = sb ? -b_EX : b_EX;
  assign b_is_zero = (b_EX == '0);

  // One radix-2 step: acc = {partial product, multiplier} or {remainder, quotient}
  assign mul_sum   = {1'b0, acc_q[ACC_W-1:WIDTH]} + (acc_q[0] ? {1'b0, opd_q} : '0);
  assign div_sh    = {acc_q, 1'b0};
  assign div_trial = div_sh[ACC_W:WIDTH] - {1'b0, opd_q};
  assign iter_val  = !is_div_q     ? {mul_sum, acc_q[WIDTH-1:1]} :
                     div_trial[WIDTH] ? div_sh[ACC_W-1:0] :
                                        {div_trial[WIDTH-1:0], div_sh[WIDTH-1:1], 1'b1};

  assign quo = acc_q[WIDTH-1:0];
  assign rem = acc_q[ACC_W-1:WIDTH];

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    opd_d    = opd_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    bzero_d  = bzero_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_EX) begin
          is_div_d = op_EX[1];
          negq_d   = sa ^ sb;
          negr_d   = sa;
          bzero_d  = op_EX[1] & b_is_zero;
          // Divide by zero keeps the raw dividend so it lands unmodified in HI
          if (op_EX[1]) begin
            acc_d = {{WIDTH{1'b0}}, (b_is_zero ? a_EX : abs_a)};
            opd_d = abs_b;
          end else begin
            acc_d = {{WIDTH{1'b0}}, abs_b};
            opd_d = abs_a;
          end
          cnt_d   = CNT_W'(WIDTH - 1);
          state_d = S_RUN;
        end else begin
          if (mthi_EX) hi_d = wdata_EX;
          if (mtlo_EX) lo_d = wdata_EX;
        end
      end
      S_RUN: begin
        acc_d = iter_val;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) state_d = S_FIX;
      end
      S_FIX: begin
        if (is_div_q) begin
          if (bzero_q) begin
            lo_d = quo;
            hi_d = rem;
          end else begin
            lo_d = negq_q ? -quo : quo;
            hi_d = negr_q ? -rem : rem;
          end
        end else begin
          {hi_d, lo_d} = negq_q ? -acc_q : acc_q;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      opd_q    <= '0;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      bzero_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      opd_q    <= opd_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      bzero_q  <= bzero_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign stall_FETCH = busy & (start_EX | hilo_read_EX | mthi_EX | mtlo_EX);
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign done        = done_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: vector table of mul/div results plus
// hand-written sequences for stalls, back-to-back issue, reset abort and MT writes.
module tb_muldiv_sequencer;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_EX;
  logic [1:0]   op_EX;
  logic [W-1:0] a_EX, b_EX, wdata_EX;
  logic         hilo_read_EX, mthi_EX, mtlo_EX;
  logic         busy, stall_FETCH, done;
  logic [W-1:0] hi, lo;

  int errors = 0;
  int checks = 0;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_EX     (start_EX),
    .op_EX        (op_EX),
    .a_EX         (a_EX),
    .b_EX         (b_EX),
    .hilo_read_EX (hilo_read_EX),
    .mthi_EX      (mthi_EX),
    .mtlo_EX      (mtlo_EX),
    .wdata_EX     (wdata_EX),
    .busy         (busy),
    .stall_FETCH  (stall_FETCH),
    .hi           (hi),
    .lo           (lo),
    .done         (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, time it to done, and check result, latency and busy span
  task automatic run_op(input string name, input logic [1:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
    int cyc;
    int bcnt;
    op_EX = op; a_EX = a; b_EX = b; start_EX = 1'b1;
    tick();
    start_EX = 1'b0; a_EX = ~a; b_EX = ~b;
    cyc = 0; bcnt = 0;
    while (!done && cyc < 100) begin
      if (busy) bcnt++;
      if (cyc == 5) chk({name, " idle-stall"}, 64'(stall_FETCH), 64'd0);
      tick();
      cyc++;
    end
    chk({name, " latency"}, 64'(cyc), 64'd33);
    chk({name, " busy-cycles"}, 64'(bcnt), 64'd33);
    chk({name, " hi"}, 64'(hi), 64'(exp_hi));
    chk({name, " lo"}, 64'(lo), 64'(exp_lo));
    tick();
    chk({name, " done-pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int cyc;
    int bad;
    int dcnt;

    vecs[0]  = '{"multu_max",   2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{"mult_m3x5",   2'b00, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[2]  = '{"div_m7d2",    2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{"divu_7d0",    2'b11, 32'd7,        32'd0,        32'd7,        32'hFFFFFFFF};
    vecs[4]  = '{"div_min_m1",  2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5]  = '{"divu_100d7",  2'b11, 32'd100,      32'd7,        32'd2,        32'd14};
    vecs[6]  = '{"mult_m1m1",   2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vecs[7]  = '{"div_7dm2",    2'b10, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[8]  = '{"div_m7d0",    2'b10, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};
    vecs[9]  = '{"multu_2p16",  2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
    vecs[10] = '{"mult_min2",   2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};

    rst = 1'b1; start_EX = 1'b0; op_EX = '0; a_EX = '0; b_EX = '0; wdata_EX = '0;
    hilo_read_EX = 1'b0; mthi_EX = 1'b0; mtlo_EX = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset stall", 64'(stall_FETCH), 64'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 11; i++)
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);

    // MULT 6*7 with an MFLO waiting behind it
    op_EX = 2'b00; a_EX = 32'd6; b_EX = 32'd7; start_EX = 1'b1;
    tick();
    start_EX = 1'b0; hilo_read_EX = 1'b1;
    cyc = 0; bad = 0;
    while (!done && cyc < 100) begin
      if (!stall_FETCH) bad++;
      tick();
      cyc++;
    end
    chk("read-stall while busy", 64'(bad), 64'd0);
    chk("read-stall done cycle", 64'(stall_FETCH), 64'd0);
    chk("read-stall lo", 64'(lo), 64'd42);
    chk("read-stall latency", 64'(cyc), 64'd33);
    hilo_read_EX = 1'b0;
    tick();

    // Second start held while busy: ignored, then accepted in the done cycle
    op_EX = 2'b01; a_EX = 32'd3; b_EX = 32'd4; start_EX = 1'b1;
    tick();
    a_EX = 32'd5; b_EX = 32'd5;
    cyc = 0; bad = 0;
    while (!done && cyc < 100) begin
      if (!stall_FETCH) bad++;
      tick();
      cyc++;
    end
    chk("b2b stall while busy", 64'(bad), 64'd0);
    chk("b2b first lo", 64'(lo), 64'd12);
    chk("b2b done-cycle stall", 64'(stall_FETCH), 64'd0);
    tick();
    start_EX = 1'b0;
    chk("b2b second accepted", 64'(busy), 64'd1);
    cyc = 1;
    while (!done && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("b2b done spacing", 64'(cyc), 64'd34);
    chk("b2b second lo", 64'(lo), 64'd25);
    tick();

    // Reset in the 10th RUN cycle aborts without commit
    op_EX = 2'b01; a_EX = 32'hFFFF; b_EX = 32'hFFFF; start_EX = 1'b1;
    tick();
    start_EX = 1'b0;
    repeat (9) tick();
    chk("pre-abort busy", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort hi", 64'(hi), 64'd0);
    chk("abort lo", 64'(lo), 64'd0);
    chk("abort done", 64'(done), 64'd0);
    tick();
    rst = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) dcnt++;
      tick();
    end
    chk("abort no done", 64'(dcnt), 64'd0);

    // MT writes in IDLE
    mthi_EX = 1'b1; wdata_EX = 32'h1234;
    #1;
    chk("mthi stall", 64'(stall_FETCH), 64'd0);
    tick();
    mthi_EX = 1'b0;
    chk("mthi hi", 64'(hi), 64'h1234);
    chk("mthi lo untouched", 64'(lo), 64'd0);
    mtlo_EX = 1'b1; wdata_EX = 32'h55;
    tick();
    mtlo_EX = 1'b0;
    chk("mtlo lo", 64'(lo), 64'h55);
    chk("mtlo hi untouched", 64'(hi), 64'h1234);

    // Start beats a simultaneous MTLO
    op_EX = 2'b01; a_EX = 32'd2; b_EX = 32'd3; start_EX = 1'b1;
    mtlo_EX = 1'b1; wdata_EX = 32'hDEAD;
    tick();
    start_EX = 1'b0; mtlo_EX = 1'b0;
    chk("mtlo dropped", 64'(lo), 64'h55);
    cyc = 0;
    while (!done && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("start-prio lo", 64'(lo), 64'd6);
    chk("start-prio hi", 64'(hi), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
